// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter onto a single-port RAM, fixed priority by default,
// round-robin when RAM_ARB_RR_EN is defined.
module ram_arbiter #(
  parameter int ADDRWIDTH = 4,
  parameter int DATAWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 p0_req,
  input  logic                 p0_we,
  input  logic [ADDRWIDTH-1:0] p0_addr,
  input  logic [DATAWIDTH-1:0] p0_wdata,
  output logic                 p0_gnt,
  output logic                 p0_rvalid,
  output logic [DATAWIDTH-1:0] p0_rdata,
  input  logic                 p1_req,
  input  logic                 p1_we,
  input  logic [ADDRWIDTH-1:0] p1_addr,
  input  logic [DATAWIDTH-1:0] p1_wdata,
  output logic                 p1_gnt,
  output logic                 p1_rvalid,
  output logic [DATAWIDTH-1:0] p1_rdata,
  output logic                 ram_cs,
  output logic                 ram_we,
  output logic                 ram_oe,
  output logic [ADDRWIDTH-1:0] ram_addr,
  output logic [DATAWIDTH-1:0] ram_wdata,
  input  logic [DATAWIDTH-1:0] ram_rdata
);
  typedef enum logic [1:0] {IDLE, WR, RD, RDCAP} state_t;
  state_t state, state_nx;
  logic run, cur_port, pick0, any_gnt;
  logic [ADDRWIDTH-1:0] cur_addr;
  logic [DATAWIDTH-1:0] cur_wdata;
`ifdef RAM_ARB_RR_EN
  logic last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= 1'b1;
    else if (any_gnt) last <= p1_gnt;
  assign pick0 = p0_req & (~p1_req | last);
`else
  assign pick0 = p0_req;
`endif
  // run keeps grants off until the first clock edge after reset release
  always_comb begin
    p0_gnt = run && state == IDLE && pick0;
    p1_gnt = run && state == IDLE && p1_req && !pick0;
    any_gnt = p0_gnt || p1_gnt;
    ram_cs = state != IDLE;
    ram_we = state == WR;
    ram_oe = state == RD || state == RDCAP;
    ram_addr = cur_addr;
    ram_wdata = cur_wdata;
    state_nx = (state == WR || state == RDCAP) ? IDLE :
               state == RD ? RDCAP :
               !any_gnt ? IDLE :
               (p1_gnt ? p1_we : p0_we) ? WR : RD;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      run <= 1'b0;
      cur_port <= 1'b0;
      cur_addr <= '0;
      cur_wdata <= '0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata <= '0;
      p1_rdata <= '0;
    end else begin
      state <= state_nx;
      run <= 1'b1;
      if (any_gnt) begin
        cur_port <= p1_gnt;
        cur_addr <= p1_gnt ? p1_addr : p0_addr;
        cur_wdata <= p1_gnt ? p1_wdata : p0_wdata;
      end
      p0_rvalid <= state == RDCAP && !cur_port;
      p1_rvalid <= state == RDCAP && cur_port;
      if (state == RDCAP && !cur_port) p0_rdata <= ram_rdata;
      if (state == RDCAP && cur_port) p1_rdata <= ram_rdata;
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter with a behavioural RAM and an expected-memory model.
module tb_ram_arbiter;
`ifdef RAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  logic p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [3:0] p0_addr = 0, p1_addr = 0;
  logic [7:0] p0_wdata = 0, p1_wdata = 0;
  logic p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [7:0] p0_rdata, p1_rdata;
  logic ram_cs, ram_we, ram_oe;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata;
  logic [7:0] mem [16];
  logic [7:0] exp_mem [16];
  logic [34:0] outs;
  int checks = 0, errors = 0;
  bit last_w = 1'b1;
  bit w0;
  ram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = ram_oe ? mem[ram_addr] : 8'h00;
  assign outs = {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, ram_cs, ram_we, ram_oe,
                 ram_addr, ram_wdata, p0_rdata, p1_rdata};
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input bit p, input bit r, input bit w, input logic [3:0] a, input logic [7:0] d);
    if (p) begin p1_req = r; p1_we = w; p1_addr = a; p1_wdata = d; end
    else begin p0_req = r; p0_we = w; p0_addr = a; p0_wdata = d; end
  endtask
  // called at a falling edge; returns at the falling edge where the next grant may appear
  task automatic op(input bit p, input bit w, input logic [3:0] a, input logic [7:0] d);
    drive(p, 1'b1, w, a, d);
    #1;
    chk("gnt", p ? p1_gnt : p0_gnt, 1);
    chk("gnt_other", p ? p0_gnt : p1_gnt, 0);
    last_w = p;
    @(posedge clk);
    #1 drive(p, 1'b0, ~w, ~a, ~d);
    @(negedge clk);
    chk("ctl", {ram_cs, ram_we, ram_oe}, w ? 3'b110 : 3'b101);
    chk("addr", ram_addr, a);
    if (w) begin
      chk("wdata", ram_wdata, d);
      exp_mem[a] = d;
      @(negedge clk);
      chk("idle_ctl", {ram_cs, ram_we, ram_oe}, 0);
    end else begin
      @(negedge clk);
      chk("rdcap_ctl", {ram_cs, ram_we, ram_oe}, 3'b101);
      chk("rvalid_early", {p1_rvalid, p0_rvalid}, 0);
      @(negedge clk);
      chk("rvalid", {p1_rvalid, p0_rvalid}, p ? 2'b10 : 2'b01);
      chk("rdata", p ? p1_rdata : p0_rdata, exp_mem[a]);
    end
  endtask
  always @(negedge clk) chk("mutex", {ram_we & ram_oe, p0_gnt & p1_gnt}, 0);
  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 16; i++) begin mem[i] = 8'h00; exp_mem[i] = 8'h00; end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    p0_req = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_outs", outs, 0);
    rst_n = 1'b1;
    #1 chk("rst_release_gnt", p0_gnt, 0);
    p0_req = 1'b0;
    @(negedge clk);
    op(0, 1, 4'd3, 8'hA5);
    op(0, 0, 4'd3, 8'h00);
    op(1, 1, 4'd5, 8'h5A);
    op(1, 0, 4'd5, 8'h00);
    chk("p0_hold", p0_rdata, 8'hA5);
    drive(0, 1, 0, 4'd3, 8'h00);
    drive(1, 1, 0, 4'd5, 8'h00);
    for (int i = 0; i < 4; i++) begin
      #1 w0 = RR ? last_w : 1'b1;
      chk("arb_p0", p0_gnt, w0);
      chk("arb_p1", p1_gnt, !w0);
      last_w = !w0;
      repeat (3) @(negedge clk);
      chk("arb_rvalid", {p1_rvalid, p0_rvalid}, w0 ? 2'b01 : 2'b10);
      chk("arb_rdata", w0 ? p0_rdata : p1_rdata, exp_mem[w0 ? 3 : 5]);
    end
    p0_req = 1'b0;
    op(1, 0, 4'd5, 8'h00);
    for (int i = 0; i < 16; i++) op(1, 1, 4'(i), 8'(i) ^ 8'hFF);
    for (int i = 0; i < 16; i++) op(1, 0, 4'(i), 8'h00);
    drive(0, 1, 0, 4'd3, 8'h00);
    #1 chk("abort_gnt", p0_gnt, 1);
    @(posedge clk);
    #1 p0_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1 chk("abort_outs", outs, 0);
    @(negedge clk);
    chk("abort_no_rvalid", {p1_rvalid, p0_rvalid}, 0);
    rst_n = 1'b1;
    drive(0, 1, 0, 4'd3, 8'h00);
    drive(1, 1, 0, 4'd5, 8'h00);
    #1 chk("post_rst_gate", {p1_gnt, p0_gnt}, 0);
    @(negedge clk);
    #1 chk("post_rst_first", {p1_gnt, p0_gnt}, 2'b01);
    p1_req = 1'b0;
    @(posedge clk);
    #1 p0_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_rvalid", {p1_rvalid, p0_rvalid}, 2'b01);
    chk("post_rst_rdata", p0_rdata, exp_mem[3]);
    @(negedge clk);
    chk("rvalid_pulse", {p1_rvalid, p0_rvalid}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDRWIDTH, default 4, RAM address width.
REQ-002 Parameter DATAWIDTH, default 8, RAM data width.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 p0_req  input  1  requester 0 access request, held until granted.
REQ-006 p0_we  input  1  requester 0 direction, 1=write, 0=read.
REQ-007 p0_addr  input  ADDRWIDTH  requester 0 address.
REQ-008 p0_wdata  input  DATAWIDTH  requester 0 write data.
REQ-009 p0_gnt  output  1  one-cycle grant pulse to requester 0.
REQ-010 p0_rvalid  output  1  one-cycle read-data-valid pulse to requester 0.
REQ-011 p0_rdata  output  DATAWIDTH  requester 0 read data.
REQ-012 p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same directions, widths and meanings as p0_*, for requester 1.
REQ-013 ram_cs  output  1  RAM chip select.
REQ-014 ram_we  output  1  RAM write enable.
REQ-015 ram_oe  output  1  RAM output enable (RAM drives its data pins).
REQ-016 ram_addr  output  ADDRWIDTH  RAM address.
REQ-017 ram_wdata  output  DATAWIDTH  data driven toward RAM data pins during writes.
REQ-018 ram_rdata  input  DATAWIDTH  data returned from RAM data pins.

Function
REQ-019 FSM states: IDLE, WR, RD, RDCAP; exactly one state active.
REQ-020 IDLE: if any req high, select winner, latch its we/addr/wdata, assert its gnt combinationally in that cycle, next state WR (we=1) or RD (we=0); no req -> stay IDLE.
REQ-021 gnt only asserted in IDLE, to at most one requester, never both.
REQ-022 Only one requesting port -> that port wins.
REQ-023 Both requesting -> winner per REQ-037/038.
REQ-024 WR (1 cycle): ram_cs=1, ram_we=1, ram_oe=0, ram_addr/ram_wdata = latched values; next IDLE; write complete at end of WR.
REQ-025 RD (1 cycle): ram_cs=1, ram_oe=1, ram_we=0, ram_addr = latched; next RDCAP.
REQ-026 RDCAP (1 cycle): same RAM controls as RD; at its closing edge register ram_rdata into winner's pX_rdata and pulse winner's pX_rvalid for the following cycle; next IDLE.
REQ-027 Latency: gnt cycle T; write at T+1; read rvalid and rdata valid at T+3; next grant possible at T+2 (write) or T+3 (read).
REQ-028 ram_we and ram_oe never simultaneously high; both 0 and ram_cs=0 in IDLE.
REQ-029 pX_rdata holds last value until that port's next read capture; other port's rdata unaffected.
REQ-030 Changes to req/we/addr/wdata after gnt do not affect the granted transaction.
REQ-031 A req held high after its gnt is treated as a new request in the next IDLE.

Reset
REQ-032 rst_n low asynchronously forces IDLE; all outputs 0 (gnt, rvalid, ram_cs/we/oe, ram_addr, ram_wdata, both rdata).
REQ-033 Reset during WR/RD/RDCAP aborts the transaction; no rvalid issued for it.
REQ-034 Round-robin pointer resets to "last winner = 1" (requester 0 first).
REQ-035 Deassertion of rst_n takes effect at the next rising clk; first grant no earlier than that edge.

Configuration
REQ-036 Macro RAM_ARB_RR_EN selects the contention policy.
REQ-037 RAM_ARB_RR_EN defined: round-robin, contention goes to the port not granted last; pointer updates on every grant.
REQ-038 RAM_ARB_RR_EN undefined: fixed priority, requester 0 always wins contention; no pointer state.

Verification
REQ-039 p0 write addr 3 data 0xA5, then p0 read addr 3 -> p0_gnt pulses, ram_we=1 one cycle, later p0_rvalid at gnt+3 with p0_rdata=0xA5.
REQ-040 p0 and p1 both req reads every cycle (RR_EN) -> grants alternate p0,p1,p0,p1; each rvalid on correct port only.
REQ-041 Same stimulus, RR_EN undefined -> p0 granted every time while held; p1 granted only when p0_req=0.
REQ-042 Back-to-back p1 writes to addrs 0..15 with data=addr^0xFF, then reads -> each read returns addr^0xFF; one grant per 2 cycles for writes, 3 for reads.
REQ-043 rst_n low during RDCAP -> all outputs 0 immediately; no rvalid; after release first contended grant goes to p0.
REQ-044 All tests -> assert ram_we&ram_oe never 1 and p0_gnt&p1_gnt never 1.
